// File: rtl/dm_ws.sv
`default_nettype none
// ============================================================================
// Module   : dm_ws
// Brief    : Parametrised single-ported data memory. Accesses use a rdy/rd_vld
//            handshake with a configurable number of wait states. An optional
//            post-reset sequencer zero-fills the array. A sticky error flag
//            records conflicting or out-of-range requests.
// Revision : 1.0 - initial release
// ============================================================================
module dm_ws #(
    parameter int DATA_WIDTH   = 17,
    parameter int DEPTH        = 1024,
    parameter int ADDR_WIDTH   = $clog2(DEPTH),
    parameter int WAIT_STATES  = 0,
    parameter bit CLEAR_ON_RST = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  re,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] wrt_data,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rdy,
    output logic                  rd_vld,
    output logic                  err
);

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_IDLE  = 2'd1,
        S_BUSY  = 2'd2
    } state_t;

    localparam state_t                C_RST_STATE = CLEAR_ON_RST ? S_CLEAR : S_IDLE;
    // One extra bit so DEPTH itself is representable for the range check
    localparam logic [ADDR_WIDTH:0]   C_DEPTH     = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] C_LAST      = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [3:0]            C_WAIT      = 4'(WAIT_STATES);

    // Storage array; never reset, only cleared by the sequencer
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    state_t                state_q,    state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q,  clr_cnt_d;
    logic [3:0]            wait_cnt_q, wait_cnt_d;
    logic                  op_we_q,    op_we_d;
    logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
    logic [DATA_WIDTH-1:0] data_q,     data_d;
    logic [DATA_WIDTH-1:0] rd_data_q,  rd_data_d;
    logic                  rd_vld_q,   rd_vld_d;
    logic                  rdy_q,      rdy_d;
    logic                  err_q,      err_d;

    logic                  w_accept;
    logic                  w_conflict;
    logic                  w_cmp;
    logic                  w_cmp_we;
    logic [ADDR_WIDTH-1:0] w_cmp_addr;
    logic [DATA_WIDTH-1:0] w_cmp_data;
    logic                  w_cmp_in_range;
    logic                  w_mem_we;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [DATA_WIDTH-1:0] w_mem_wdata;

    // Request decode: exactly one of re/we is a legal request, both is an error
    always_comb begin
        w_conflict = rdy_q & re & we;
        w_accept   = rdy_q & (re ^ we);
    end

    // Next-state, completion and memory-port steering
    always_comb begin
        state_d        = state_q;
        clr_cnt_d      = clr_cnt_q;
        wait_cnt_d     = wait_cnt_q;
        op_we_d        = op_we_q;
        addr_d         = addr_q;
        data_d         = data_q;
        rd_data_d      = rd_data_q;
        rd_vld_d       = 1'b0;
        err_d          = err_q;
        w_cmp          = 1'b0;
        w_cmp_we       = op_we_q;
        w_cmp_addr     = addr_q;
        w_cmp_data     = data_q;
        w_mem_we       = 1'b0;
        w_mem_addr     = clr_cnt_q;
        w_mem_wdata    = '0;

        case (state_q)
            S_CLEAR: begin
                // Zero one word per cycle; requests are ignored meanwhile
                w_mem_we    = 1'b1;
                w_mem_addr  = clr_cnt_q;
                w_mem_wdata = '0;
                if (clr_cnt_q == C_LAST) begin
                    clr_cnt_d = '0;
                    state_d   = S_IDLE;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            S_IDLE: begin
                if (w_conflict) begin
                    err_d = 1'b1;
                end else if (w_accept) begin
                    op_we_d    = we;
                    addr_d     = addr;
                    data_d     = wrt_data;
                    wait_cnt_d = C_WAIT;
                    if (WAIT_STATES == 0) begin
                        // Zero-wait access completes on the accepting edge
                        w_cmp      = 1'b1;
                        w_cmp_we   = we;
                        w_cmp_addr = addr;
                        w_cmp_data = wrt_data;
                    end else begin
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                wait_cnt_d = wait_cnt_q - 1'b1;
                if (wait_cnt_q == 4'd1) begin
                    w_cmp   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = C_RST_STATE;
            end
        endcase

        w_cmp_in_range = ({1'b0, w_cmp_addr} < C_DEPTH);

        if (w_cmp) begin
            if (!w_cmp_in_range) begin
                // Out-of-range: drop writes, reads return zero
                err_d = 1'b1;
                if (!w_cmp_we) begin
                    rd_data_d = '0;
                    rd_vld_d  = 1'b1;
                end
            end else if (w_cmp_we) begin
                w_mem_we    = 1'b1;
                w_mem_addr  = w_cmp_addr;
                w_mem_wdata = w_cmp_data;
            end else begin
                rd_data_d = mem_q[w_cmp_addr];
                rd_vld_d  = 1'b1;
            end
        end

        rdy_d = (state_d == S_IDLE);
    end

    // Control and output registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= C_RST_STATE;
            clr_cnt_q  <= '0;
            wait_cnt_q <= '0;
            op_we_q    <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            rd_data_q  <= '0;
            rd_vld_q   <= 1'b0;
            rdy_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            op_we_q    <= op_we_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            rd_data_q  <= rd_data_d;
            rd_vld_q   <= rd_vld_d;
            rdy_q      <= rdy_d;
            err_q      <= err_d;
        end
    end

    // Array write port; blocked while reset is held so a pending write never commits
    always_ff @(posedge clk) begin
        if (w_mem_we && !rst) begin
            mem_q[w_mem_addr] <= w_mem_wdata;
        end
    end

    assign rd_data = rd_data_q;
    assign rd_vld  = rd_vld_q;
    assign rdy     = rdy_q;
    assign err     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_dm_ws.sv
`default_nettype none
// ============================================================================
// Module   : tb_dm_ws
// Brief    : Self-checking bench for dm_ws. Instance A: DEPTH=1024, zero wait
//            states. Instance B: DEPTH=1000, three wait states. Reads push the
//            expected word into a per-instance queue; a monitor pops and
//            compares on every rd_vld.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dm_ws;

    logic        clk;
    logic        rst  [2];
    logic [9:0]  addr [2];
    logic        re   [2];
    logic        we   [2];
    logic [16:0] wd   [2];
    logic [16:0] rdd  [2];
    logic        rdy  [2];
    logic        vld  [2];
    logic        err  [2];

    int          n_vec;
    int          n_fail;
    logic [16:0] q0 [$];
    logic [16:0] q1 [$];

    dm_ws #(.DATA_WIDTH(17), .DEPTH(1024), .WAIT_STATES(0), .CLEAR_ON_RST(1'b1)) u_a (
        .clk(clk), .rst(rst[0]), .addr(addr[0]), .re(re[0]), .we(we[0]),
        .wrt_data(wd[0]), .rd_data(rdd[0]), .rdy(rdy[0]), .rd_vld(vld[0]), .err(err[0])
    );

    dm_ws #(.DATA_WIDTH(17), .DEPTH(1000), .WAIT_STATES(3), .CLEAR_ON_RST(1'b1)) u_b (
        .clk(clk), .rst(rst[1]), .addr(addr[1]), .re(re[1]), .we(we[1]),
        .wrt_data(wd[1]), .rd_data(rdd[1]), .rdy(rdy[1]), .rd_vld(vld[1]), .err(err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Wait (bounded) for rdy, present one request for one edge
    task automatic issue(input int i, input logic r, input logic w,
                         input logic [9:0] a, input logic [16:0] d, input logic [16:0] x);
        int n;
        n = 0;
        while (!rdy[i] && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (!rdy[i]) begin
            n_vec++;
            n_fail++;
            $display("FAIL rdy_timeout inst %0d: rdy=%0b, expected 1", i, rdy[i]);
        end
        re[i] = r; we[i] = w; addr[i] = a; wd[i] = d;
        if (r && !w) begin
            if (i == 0) q0.push_back(x);
            else        q1.push_back(x);
        end
        @(posedge clk); #1;
        re[i] = 1'b0; we[i] = 1'b0;
    endtask

    task automatic wait_rdy(input int i);
        int n;
        n = 0;
        while (!rdy[i] && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (!rdy[i]) begin
            n_vec++;
            n_fail++;
            $display("FAIL wait_rdy inst %0d: rdy=%0b, expected 1", i, rdy[i]);
        end
    endtask

    // Scoreboard monitor: every rd_vld pulse must match the oldest expected read
    always @(negedge clk) begin
        logic [16:0] e;
        if (vld[0]) begin
            if (q0.size() == 0) begin
                n_vec++; n_fail++;
                $display("FAIL unexpected_rd_vld_a: rd_data=%0h, no read pending", rdd[0]);
            end else begin
                e = q0.pop_front();
                chk("rd_data_a", {15'd0, rdd[0]}, {15'd0, e});
            end
        end
        if (vld[1]) begin
            if (q1.size() == 0) begin
                n_vec++; n_fail++;
                $display("FAIL unexpected_rd_vld_b: rd_data=%0h, no read pending", rdd[1]);
            end else begin
                e = q1.pop_front();
                chk("rd_data_b", {15'd0, rdd[1]}, {15'd0, e});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int t0, t1, low;
        n_vec  = 0;
        n_fail = 0;
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; re[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wd[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("reset_rdy",     {31'd0, rdy[i]}, 32'd0);
            chk("reset_rd_vld",  {31'd0, vld[i]}, 32'd0);
            chk("reset_rd_data", {15'd0, rdd[i]}, 32'd0);
            chk("reset_err",     {31'd0, err[i]}, 32'd0);
        end

        // Clear length: rdy rises exactly DEPTH edges after reset release
        rst[0] = 1'b0; rst[1] = 1'b0;
        t0 = 0; t1 = 0;
        for (int n = 1; n <= 1200 && (t0 == 0 || t1 == 0); n++) begin
            @(posedge clk); #1;
            if (rdy[0] && t0 == 0) t0 = n;
            if (rdy[1] && t1 == 0) t1 = n;
        end
        chk("clear_len_a", t0, 1024);
        chk("clear_len_b", t1, 1000);

        // Instance A: cleared contents, zero-wait write/read, conflict
        issue(0, 1'b1, 1'b0, 10'd0,    17'h0, 17'h0);
        issue(0, 1'b1, 1'b0, 10'd517,  17'h0, 17'h0);
        issue(0, 1'b1, 1'b0, 10'd1023, 17'h0, 17'h0);
        issue(0, 1'b0, 1'b1, 10'd5, 17'h1ABCD, 17'h0);
        chk("rdy_after_write_a", {31'd0, rdy[0]}, 32'd1);
        issue(0, 1'b1, 1'b0, 10'd5, 17'h0, 17'h1ABCD);
        chk("rd_vld_latency_a", {31'd0, vld[0]}, 32'd1);
        chk("rdy_after_read_a", {31'd0, rdy[0]}, 32'd1);
        issue(0, 1'b0, 1'b1, 10'd1023, 17'h00001, 17'h0);
        issue(0, 1'b0, 1'b1, 10'd0,    17'h1FFFF, 17'h0);
        issue(0, 1'b1, 1'b0, 10'd0,    17'h0, 17'h1FFFF);
        issue(0, 1'b1, 1'b0, 10'd1023, 17'h0, 17'h00001);
        chk("err_before_conflict_a", {31'd0, err[0]}, 32'd0);
        issue(0, 1'b1, 1'b1, 10'd9, 17'h00055, 17'h0);
        chk("err_after_conflict_a", {31'd0, err[0]}, 32'd1);
        issue(0, 1'b1, 1'b0, 10'd9, 17'h0, 17'h0);

        // Instance B: three wait states
        issue(1, 1'b0, 1'b1, 10'd5, 17'h12345, 17'h0);
        issue(1, 1'b1, 1'b0, 10'd5, 17'h0, 17'h12345);
        low = 0;
        while (!rdy[1] && low < 50) begin
            low++;
            if (low == 1) begin
                we[1] = 1'b1; addr[1] = 10'd5; wd[1] = 17'h00AAA;
            end
            @(posedge clk); #1;
            we[1] = 1'b0;
        end
        chk("busy_cycles_b", low, 3);
        chk("rd_vld_at_done_b", {31'd0, vld[1]}, 32'd1);
        issue(1, 1'b1, 1'b0, 10'd5, 17'h0, 17'h12345);
        chk("err_no_busy_flag_b", {31'd0, err[1]}, 32'd0);

        // Instance B: out-of-range address
        issue(1, 1'b0, 1'b1, 10'd1000, 17'h1FFFF, 17'h0);
        wait_rdy(1);
        chk("err_oor_b", {31'd0, err[1]}, 32'd1);
        issue(1, 1'b1, 1'b0, 10'd1000, 17'h0, 17'h0);
        issue(1, 1'b1, 1'b0, 10'd999,  17'h0, 17'h0);
        issue(1, 1'b1, 1'b0, 10'd0,    17'h0, 17'h0);
        issue(1, 1'b1, 1'b0, 10'd5,    17'h0, 17'h12345);

        // Instance B: reset two edges into a pending write
        issue(1, 1'b0, 1'b1, 10'd3, 17'h0F0F0, 17'h0);
        @(posedge clk); #1;
        rst[1] = 1'b1;
        #1;
        chk("midrst_rdy",     {31'd0, rdy[1]}, 32'd0);
        chk("midrst_rd_vld",  {31'd0, vld[1]}, 32'd0);
        chk("midrst_rd_data", {15'd0, rdd[1]}, 32'd0);
        chk("midrst_err",     {31'd0, err[1]}, 32'd0);
        @(posedge clk); #1;
        rst[1] = 1'b0;
        t1 = 0;
        for (int n = 1; n <= 1200 && t1 == 0; n++) begin
            @(posedge clk); #1;
            if (rdy[1]) t1 = n;
        end
        chk("reclear_len_b", t1, 1000);
        issue(1, 1'b1, 1'b0, 10'd3, 17'h0, 17'h0);
        issue(1, 1'b1, 1'b0, 10'd5, 17'h0, 17'h0);

        // Drain: every expected read must have been presented
        repeat (10) @(posedge clk);
        #1;
        chk("pending_reads_a", q0.size(), 0);
        chk("pending_reads_b", q1.size(), 0);
        chk("err_sticky_a", {31'd0, err[0]}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
